// File: rtl/divisor_pkg.sv
// Shared types and helpers for the restoring divider.
//   estado_t   : FSM states of the divider
//   TAMANO_DEF : default operand width
//   neg_cond   : conditional two's complement negation (wide; callers truncate)
package divisor_pkg;

  localparam int unsigned TAMANO_DEF = 8;
  localparam int unsigned ANCHO_MAX  = 64;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    FIN  = 3'd4
  } estado_t;

  // Negation is width-agnostic in the low bits, so callers zero-extend in and
  // truncate out; the low bits are exact two's complement at any width.
  function automatic logic [ANCHO_MAX-1:0] neg_cond(input logic [ANCHO_MAX-1:0] x,
                                                    input logic                 neg);
    return neg ? (~x + ANCHO_MAX'(1)) : x;
  endfunction

endpackage

// File: rtl/divisor_restoring_paso.sv
// One combinational restoring-division iteration.
//   a_i         : partial remainder A (W+1 bits)
//   q_msb_i     : bit shifted out of the quotient register into A
//   m_i         : divisor magnitude
//   a_nuevo_o_c : next partial remainder (restored or reduced)
//   q_bit_o_c   : quotient bit produced by this iteration
module paso_restador #(
  parameter int unsigned W = 8
) (
  input  logic [W:0]   a_i,
  input  logic         q_msb_i,
  input  logic [W-1:0] m_i,
  output logic [W:0]   a_nuevo_o_c,
  output logic         q_bit_o_c
);

  // One spare bit above A so the trial subtraction's sign is never ambiguous.
  logic [W+1:0] desplazado;
  logic [W+1:0] tentativo;

  always_comb begin
    desplazado  = {a_i, q_msb_i};
    tentativo   = desplazado - {2'b00, m_i};
    a_nuevo_o_c = (W+1)'(tentativo);
    q_bit_o_c   = 1'b1;
    if (tentativo[W+1]) begin
      a_nuevo_o_c = (W+1)'(desplazado);
      q_bit_o_c   = 1'b0;
    end
  end

endmodule

// File: rtl/divisor_restoring.sv
// Sequential signed restoring divider, one quotient bit per clock.
//   CLOCK/RESET : rising-edge clock, asynchronous active-low reset
//   START       : request, sampled only in IDLE
//   dividendo   : signed dividend, divisor : signed divisor (captured on accept)
//   cociente    : signed quotient, resto : signed remainder (held until next accept)
//   BUSY        : high from the accepting edge until FIN is left
//   DONE        : one-cycle pulse, results valid while high
//   DIV0        : divide-by-zero flag, valid with DONE
module divisor_restoring
  import divisor_pkg::*;
#(
  parameter int unsigned tamano = TAMANO_DEF
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              START,
  input  logic [tamano-1:0] dividendo,
  input  logic [tamano-1:0] divisor,
  output logic [tamano-1:0] cociente,
  output logic [tamano-1:0] resto,
  output logic              BUSY,
  output logic              DONE,
  output logic              DIV0
);

  localparam int unsigned W  = tamano;
  localparam int unsigned CW = $clog2(tamano + 1);

  estado_t       estado_q, estado_d;
  logic [W:0]    a_q, a_d;
  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  m_q, m_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sd_q, sd_d;
  logic          sv_q, sv_d;
  logic [W-1:0]  dvd_q, dvd_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [W-1:0]  coc_q, coc_d;
  logic [W-1:0]  resto_q, resto_d;
  logic          div0_q, div0_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [W:0]    a_nuevo;
  logic          q_bit;

  paso_restador #(.W(W)) u_paso (
    .a_i         (a_q),
    .q_msb_i     (q_q[W-1]),
    .m_i         (m_q),
    .a_nuevo_o_c (a_nuevo),
    .q_bit_o_c   (q_bit)
  );

  // State and datapath registers.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      estado_q <= IDLE;
      a_q      <= '0;
      q_q      <= '0;
      m_q      <= '0;
      cnt_q    <= '0;
      sd_q     <= 1'b0;
      sv_q     <= 1'b0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      coc_q    <= '0;
      resto_q  <= '0;
      div0_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      a_q      <= a_d;
      q_q      <= q_d;
      m_q      <= m_d;
      cnt_q    <= cnt_d;
      sd_q     <= sd_d;
      sv_q     <= sv_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      coc_q    <= coc_d;
      resto_q  <= resto_d;
      div0_q   <= div0_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    estado_d = estado_q;
    a_d      = a_q;
    q_d      = q_q;
    m_d      = m_q;
    cnt_d    = cnt_q;
    sd_d     = sd_q;
    sv_d     = sv_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    coc_d    = coc_q;
    resto_d  = resto_q;
    div0_d   = div0_q;

    case (estado_q)
      IDLE: begin
        if (START) begin
          dvd_d    = dividendo;
          dvs_d    = divisor;
          sd_d     = dividendo[W-1];
          sv_d     = divisor[W-1];
          div0_d   = 1'b0;
          estado_d = LOAD;
        end
      end
      LOAD: begin
        // Divide-by-zero passes through FIX so both paths publish results
        // from the same stage, two edges after acceptance at the earliest.
        if (dvs_q == '0) begin
          div0_d   = 1'b1;
          estado_d = FIX;
        end else begin
          q_d      = W'(neg_cond(ANCHO_MAX'(dvd_q), sd_q));
          m_d      = W'(neg_cond(ANCHO_MAX'(dvs_q), sv_q));
          a_d      = '0;
          cnt_d    = CW'(W);
          estado_d = DIV;
        end
      end
      DIV: begin
        a_d   = a_nuevo;
        q_d   = {q_q[W-2:0], q_bit};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          estado_d = FIX;
        end
      end
      FIX: begin
        if (div0_q) begin
          coc_d   = '1;
          resto_d = dvd_q;
        end else begin
          coc_d   = W'(neg_cond(ANCHO_MAX'(q_q), sd_q ^ sv_q));
          resto_d = W'(neg_cond(ANCHO_MAX'(a_q[W-1:0]), sd_q));
        end
        estado_d = FIN;
      end
      FIN: begin
        estado_d = IDLE;
      end
      default: begin
        estado_d = IDLE;
      end
    endcase

    busy_d = (estado_d != IDLE);
    done_d = (estado_d == FIN);
  end

  assign cociente = coc_q;
  assign resto    = resto_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign DIV0     = div0_q;

endmodule
